// File: rtl/tx_buffer.sv
// SPI-fed DAC sample buffer: the host shifts framed 14-bit samples into a FIFO,
// and the FIFO drains one sample per txstrobe. SPI pins are oversampled on tx_clk.
module tx_buffer #(
    parameter int unsigned FIFO_AW  = 9,
    parameter logic [3:0]  SYNC_NIB = 4'hA
) (
    input  logic               tx_clk,
    input  logic               reset_n,
    input  logic               spi_clk,
    input  logic               spi_input,
    input  logic               spi_cs1,
    output logic               spi_output,
    output logic               spi_output_en,
    input  logic               tx_enable,
    input  logic               txstrobe,
    input  logic               clear_status,
    output logic [13:0]        tx_data,
    output logic               tx_valid,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               tx_underrun,
    output logic               tx_overrun,
    output logic [15:0]        debug_bus
);
    localparam int unsigned LW      = FIFO_AW + 1;
    localparam int unsigned DEPTH   = 1 << FIFO_AW;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, HEADER, DATA, DISCARD} state_t;

    logic [2:0] cs_sync_reg, sclk_sync_reg;
    logic [1:0] sdi_sync_reg;
    logic       cs_high, cs_fall, sclk_rise, sclk_fall, sdi;

    state_t              state_reg, state_next;
    logic [3:0]          bit_cnt_reg, bit_cnt_next;
    logic [14:0]         sreg_reg, sreg_next;
    logic [LW-1:0]       words_left_reg, words_left_next;
    logic [15:0]         somi_reg, somi_next;
    logic [15:0]         word;
    logic [15:0]         status;
    logic [31:0]         free_full;
    logic [13:0]         free14;

    logic [FIFO_AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]       level_reg;
    logic [13:0]         tx_data_reg;
    logic                tx_valid_reg, underrun_reg, overrun_reg;
    logic                fifo_full, fifo_empty, fifo_wr, fifo_rd;
    logic                overrun_evt, underrun_evt;
    logic [13:0]         mem [DEPTH];
    logic [9:0]          dbg_level;

    // Two flops of metastability settling; the third flop only serves edge detection.
    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync_reg   <= 3'b111;
            sclk_sync_reg <= 3'b000;
            sdi_sync_reg  <= 2'b00;
        end else begin
            cs_sync_reg   <= {cs_sync_reg[1:0], spi_cs1};
            sclk_sync_reg <= {sclk_sync_reg[1:0], spi_clk};
            sdi_sync_reg  <= {sdi_sync_reg[0], spi_input};
        end
    end

    assign cs_high   = cs_sync_reg[1];
    assign cs_fall   = ~cs_sync_reg[1] & cs_sync_reg[2];
    assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
    assign sclk_fall = ~sclk_sync_reg[1] & sclk_sync_reg[2];
    assign sdi       = sdi_sync_reg[1];
    assign word      = {sreg_reg, sdi};

    assign fifo_full    = (level_reg == DEPTH_L);
    assign fifo_empty   = (level_reg == '0);
    assign fifo_rd      = txstrobe & tx_enable & ~fifo_empty;
    assign underrun_evt = txstrobe & tx_enable & fifo_empty;

    assign free_full = DEPTH - 32'(level_reg);
    assign free14    = (free_full > 32'd16383) ? 14'h3FFF : free_full[13:0];
    assign status    = {underrun_reg, overrun_reg, free14};

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            sreg_reg       <= '0;
            words_left_reg <= '0;
            somi_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            sreg_reg       <= sreg_next;
            words_left_reg <= words_left_next;
            somi_reg       <= somi_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        sreg_next       = sreg_reg;
        words_left_next = words_left_reg;
        fifo_wr         = 1'b0;
        overrun_evt     = 1'b0;
        if (cs_high) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
        end else if (cs_fall) begin
            state_next   = HEADER;
            bit_cnt_next = '0;
        end else if (sclk_rise && state_reg != IDLE) begin
            sreg_next    = word[14:0];
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd15) begin
                case (state_reg)
                    HEADER: begin
                        if (word[15:12] == SYNC_NIB && word[11:0] != 12'd0 &&
                            {20'd0, word[11:0]} <= DEPTH) begin
                            state_next      = DATA;
                            words_left_next = word[LW-1:0];
                        end else begin
                            state_next = DISCARD;
                        end
                    end
                    DATA: begin
                        words_left_next = words_left_reg - LW'(1);
                        if (!fifo_full) begin
                            fifo_wr = 1'b1;
                            if (words_left_reg == LW'(1))
                                state_next = DISCARD;
                        end else begin
                            overrun_evt = 1'b1;
                            state_next  = DISCARD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Status word loads on CS fall and empties toward zero, so SOMI idles low after the header.
    always_comb begin
        somi_next = somi_reg;
        if (cs_high)
            somi_next = '0;
        else if (cs_fall)
            somi_next = status;
        else if (sclk_fall)
            somi_next = {somi_reg[14:0], 1'b0};
    end

    assign spi_output_en = ~cs_sync_reg[1];
    assign spi_output    = spi_output_en & (cs_fall ? status[15] : somi_reg[15]);

    always_ff @(posedge tx_clk) begin
        if (fifo_wr)
            mem[wr_ptr_reg] <= word[13:0];
    end

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            tx_valid_reg <= 1'b0;
            underrun_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            if (fifo_wr)
                wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
            if (fifo_rd)
                rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
            case ({fifo_wr, fifo_rd})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: ;
            endcase
            tx_valid_reg <= fifo_rd;
            if (underrun_evt)
                underrun_reg <= 1'b1;
            else if (clear_status)
                underrun_reg <= 1'b0;
            if (overrun_evt)
                overrun_reg <= 1'b1;
            else if (clear_status)
                overrun_reg <= 1'b0;
        end
    end

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n)
            tx_data_reg <= '0;
        else if (!tx_enable)
            tx_data_reg <= '0;
        else if (fifo_rd)
            tx_data_reg <= mem[rd_ptr_reg];
        else if (underrun_evt)
            tx_data_reg <= '0;
    end

    generate
        if (LW >= 10) begin : g_dbg_trunc
            assign dbg_level = level_reg[9:0];
        end else begin : g_dbg_ext
            assign dbg_level = {{(10 - LW){1'b0}}, level_reg};
        end
    endgenerate

    assign tx_data     = tx_data_reg;
    assign tx_valid    = tx_valid_reg;
    assign fifo_level  = level_reg;
    assign tx_underrun = underrun_reg;
    assign tx_overrun  = overrun_reg;
    assign debug_bus   = {state_reg, bit_cnt_reg, dbg_level};
endmodule
